// File: rtl/piso_pkg.sv
// piso_pkg: shared types and sizing helpers for the PISO serializer.
// Optional feature macro: PISO_PARITY_EN (even parity bit after each word).
`default_nettype none

package piso_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    // Counter width for a WIDTH-bit word; floor of 1 keeps the vector legal.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ser_bit_counter.sv
// ser_bit_counter: bit position counter for the serializer, flags the word's final data bit.
`default_nettype none

module ser_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic inc_i,
    output logic last_o
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

`default_nettype wire

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready word in, MSB-first serial stream out, gapless back-to-back.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit to every word.
`default_nettype none

module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] din_i,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    output logic             sout_o,
    output logic             sout_valid_o,
    output logic             word_done_o,
    output logic             busy_o
);

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic             last_data_bit;
    logic             final_bit;
    logic             take;

    ser_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (take),
        .inc_i   (state_q == SHIFT),
        .last_o  (last_data_bit)
    );

`ifdef PISO_PARITY_EN
    logic par_q;

    assign final_bit = (state_q == PARITY);
`else
    assign final_bit = (state_q == SHIFT) && last_data_bit;
`endif

    // Ready only depends on state (and reset), never on din_valid_i.
    assign din_ready_o = rst_ni && ((state_q == IDLE) || final_bit);
    assign take        = din_valid_i && din_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            shreg_q <= '0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (take) begin
            state_q <= SHIFT;
            shreg_q <= din_i;
`ifdef PISO_PARITY_EN
            par_q   <= ^din_i;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
                    if (last_data_bit) begin
`ifdef PISO_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= IDLE;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        sout_o = 1'b0;
        case (state_q)
            SHIFT:   sout_o = shreg_q[WIDTH-1];
`ifdef PISO_PARITY_EN
            PARITY:  sout_o = par_q;
`endif
            default: sout_o = 1'b0;
        endcase
    end

    assign busy_o       = (state_q != IDLE);
    assign sout_valid_o = busy_o;
    assign word_done_o  = final_bit;

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed + random stimulus against a bit-queue reference model.
`default_nettype none

module tb_piso_serializer;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         sout;
    logic         sout_valid;
    logic         word_done;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_q[$];

    piso_serializer #(
        .WIDTH (W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .din_i        (din),
        .din_valid_i  (din_valid),
        .din_ready_o  (din_ready),
        .sout_o       (sout),
        .sout_valid_o (sout_valid),
        .word_done_o  (word_done),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: queue holds the serial bits still to appear; head is the current bit.
    task automatic check_outputs(input string tag);
        bit live;
        live = (exp_q.size() > 0);
        check({tag, ".sout_valid"}, 32'(sout_valid), 32'(live));
        check({tag, ".busy"},       32'(busy),       32'(live));
        check({tag, ".sout"},       32'(sout),       live ? 32'(exp_q[0]) : 32'd0);
        check({tag, ".word_done"},  32'(word_done),  32'(exp_q.size() == 1));
        check({tag, ".din_ready"},  32'(din_ready),  32'(rst_n && (exp_q.size() <= 1)));
    endtask

    task automatic push_word(input logic [W-1:0] d);
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef PISO_PARITY_EN
        exp_q.push_back(^d);
`endif
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic step(input string tag, input logic v, input logic [W-1:0] d);
        bit rdy;
        check_outputs(tag);
        din_valid = v;
        din       = d;
        rdy       = rst_n && (exp_q.size() <= 1);
        @(posedge clk);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (v && rdy) push_word(d);
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        repeat (NB + 1) step(tag, 1'b0, '0);
    endtask

    initial begin
        // Reset held with a valid word offered: nothing may be taken.
        din_valid = 1'b1;
        din       = 4'b1111;
        repeat (2) begin
            @(negedge clk);
            #1;
            check_outputs("reset");
        end
        rst_n     = 1'b1;
        din_valid = 1'b0;
        #1;
        check("release.din_ready", 32'(din_ready), 32'd1);

        step("single", 1'b1, 4'b1010);
        drain("single");

        // Back-to-back with valid held: second word taken on first word's last bit.
        step("b2b", 1'b1, 4'b1010);
        repeat (NB) step("b2b", 1'b1, 4'b0110);
        drain("b2b");

        // Backpressure: a new word offered mid-shift must wait.
        step("bp", 1'b1, 4'b1001);
        step("bp", 1'b0, 4'b0000);
        repeat (NB - 1) step("bp", 1'b1, 4'b0110);
        drain("bp");

        // Asynchronous reset after two bits of a word.
        step("mid", 1'b1, 4'b1100);
        step("mid", 1'b0, 4'b0000);
        step("mid", 1'b0, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("arst.sout",       32'(sout),       32'd0);
        check("arst.sout_valid", 32'(sout_valid), 32'd0);
        check("arst.busy",       32'(busy),       32'd0);
        check("arst.word_done",  32'(word_done),  32'd0);
        check("arst.din_ready",  32'(din_ready),  32'd0);
        @(negedge clk);
        #1;
        check_outputs("arst_hold");
        rst_n = 1'b1;
        #1;
        step("after", 1'b1, 4'b0101);
        drain("after");

`ifdef PISO_PARITY_EN
        step("par", 1'b1, 4'b1011);
        drain("par");
        step("par", 1'b1, 4'b1001);
        drain("par");
`endif

        repeat (400) begin
            step("rand", ($urandom_range(0, 99) < 65), W'($urandom));
        end
        repeat (40) step("burst", 1'b1, W'($urandom));
        drain("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage that accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock, MSB first. It sits directly upstream of the serial sequence detectors, such as the 1010 detector: SOUT drives the detector's IN. Back-to-back words are streamed with no idle bit between them. An optional parity bit can follow each word.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32
- CLK  input  1  rising-edge clock
- RESET  input  1  asynchronous, active-low reset; low clears all state immediately
- DIN  input  WIDTH  parallel word; sampled only on an accepted transfer
- DIN_VALID  input  1  upstream has a word on DIN
- DIN_READY  output  1  block can accept a word this cycle (combinational from state)
- SOUT  output  1  serial data bit, MSB first
- SOUT_VALID  output  1  SOUT carries a live bit this cycle
- WORD_DONE  output  1  one-cycle pulse, coincident with the final serial bit of a word
- BUSY  output  1  high while any word is being shifted out

## Operation
- States: IDLE, SHIFT, and PARITY (PARITY exists only with the macro).
- Transfer occurs on a rising CLK edge when DIN_VALID && DIN_READY.
  - On transfer: shift register <= DIN, bit counter <= 0, state <= SHIFT.
- SHIFT
  - SOUT = shreg[WIDTH-1]; each edge shifts left by one, filling with 0, and increments the counter.
  - Counter width is $clog2(WIDTH).
- DIN_READY
  - High in IDLE.
  - High in SHIFT when counter == WIDTH-1, but only without parity.
  - High in PARITY.
  - Otherwise low.
  - Forced low while RESET is low.
- Last bit (counter == WIDTH-1, or the PARITY state)
  - WORD_DONE = 1.
  - If a transfer occurs on this edge, reload and stay in SHIFT (gapless).
  - Otherwise go to IDLE.
- IDLE: SOUT = 0, SOUT_VALID = 0, BUSY = 0.
- SOUT_VALID = BUSY = (state != IDLE).
- DIN changes while the block is not ready are ignored. DIN_VALID held high with DIN_READY low is legal and not an error.
- Reset mid-word: the word is discarded, the state returns to IDLE, and no WORD_DONE is generated.

## Timing
- Reset values: SOUT 0, SOUT_VALID 0, WORD_DONE 0, BUSY 0, DIN_READY 0 (while RESET is low). DIN_READY becomes 1 once RESET is high.
- Latency: a word accepted at edge k drives its MSB on SOUT in the cycle after edge k.
  - Bit i (counting from the MSB) appears after edge k+i.
- A word occupies exactly WIDTH cycles of SOUT_VALID, or WIDTH+1 with parity.
- Sustained throughput: one bit per cycle; with DIN_VALID held high, SOUT_VALID never drops.
- All outputs except DIN_READY are registered or decoded purely from registers. There is no combinational path from DIN or DIN_VALID to SOUT.

## Configuration
- PISO_PARITY_EN defined
  - Even parity, ^DIN, is captured at transfer and emitted as one extra bit in the PARITY state after the LSB.
  - WORD_DONE is asserted in the PARITY cycle, not on the LSB.
  - DIN_READY is asserted in PARITY, not on the LSB.
- PISO_PARITY_EN undefined
  - The PARITY state and parity register are absent.
  - Words are exactly WIDTH bits; WORD_DONE is asserted on the LSB.

## Structure
- Package piso_pkg holds:
  - the state enum (IDLE, SHIFT, PARITY);
  - localparam CNT_W = $clog2(WIDTH), provided as a function of WIDTH;
  - the default WIDTH constant.
- One natural sub-module, ser_bit_counter:
  - clear on transfer, increment in SHIFT;
  - exposes a last-bit flag.
- The shift register and FSM stay in the top level.

## Test plan
- Reset: hold RESET low for 2 cycles with DIN_VALID=1 -> all outputs 0 and no transfer occurs; release -> DIN_READY=1 in IDLE.
- Single word, WIDTH=4, DIN=4'b1010 -> SOUT 1,0,1,0 on the 4 cycles after acceptance; SOUT_VALID high for exactly 4 cycles; WORD_DONE high on the 4th bit; a downstream 1010 detector fires once.
- Back-to-back, WIDTH=4, DIN_VALID held, words 4'b1010 then 4'b0110 -> 8 contiguous SOUT_VALID cycles, SOUT 1,0,1,0,0,1,1,0; DIN_READY pulses on the last bit of each word.
- Backpressure: present a new word mid-shift (counter=1) -> DIN_READY=0, word not taken; it is accepted only on the last-bit cycle, and the current word is unaltered.
- Reset mid-operation: assert RESET low asynchronously after 2 of 4 bits -> SOUT, SOUT_VALID and BUSY go to 0 immediately; no WORD_DONE; next word starts cleanly from its MSB.
- PISO_PARITY_EN, WIDTH=4, DIN=4'b1011 -> SOUT 1,0,1,1,1 (5 bits, parity=1); WORD_DONE on the 5th bit; DIN=4'b1001 -> parity bit 0.
